hslp_dot_acc: RTL and testbench
===============================

# hslp_dot_acc

Streaming accumulator that sits directly downstream of the team's 8x8 approximate multipliers. It takes one 16-bit unsigned approximate product per beat and sums a vector of up to LEN products into a saturating accumulator. It then presents the dot-product result on a valid/ready output port. It is used to measure approximate-MAC behaviour on FPGA without changing the multiplier itself.

## Interface
- ACC_W, 24: accumulator and result width in bits. Must be 17 or more.
- LEN, 16: maximum products per vector. Must be 1 or more.
- CNT_W, $clog2(LEN+1): width of the beat counter and out_count. Derived; do not override.
- clk  in  1  sole clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a product beat is present on the input.
- in_ready  out  1  the block can accept a beat this cycle.
- prod  in  16  unsigned approximate product from the multiplier.
- in_last  in  1  this beat is the final beat of the vector. Qualified by in_valid.
- out_valid  out  1  the result registers hold a completed vector.
- out_ready  in  1  the downstream stage accepts the result.
- out_sum  out  ACC_W  saturated sum of the vector's products.
- out_count  out  CNT_W  number of beats accumulated into out_sum.
- out_ovf  out  1  saturation occurred at some point during this vector.

## Operation
- The FSM has two states, ACC and HOLD. Reset puts it in ACC.
- A beat is accepted when in_valid && in_ready.
- ACC state:
  - in_ready = 1 and out_valid = 0.
  - On each accepted beat: acc <= sat(acc + prod), cnt <= cnt + 1, ovf <= ovf | (saturation on this beat).
- Vector termination: a vector ends on an accepted beat that has in_last = 1, or when cnt + 1 == LEN.
  - The result registers load the post-add values of acc, cnt and ovf.
  - acc, cnt and ovf clear to 0.
  - The FSM moves to HOLD.
- HOLD state:
  - in_ready = 0 and out_valid = 1.
  - out_sum, out_count and out_ovf stay stable until out_ready = 1.
  - On out_valid && out_ready the FSM returns to ACC on the next cycle.
- Saturation rule: sat(x) = min(x, 2^ACC_W − 1). The add is computed at ACC_W+1 bits. Once acc reaches 2^ACC_W − 1 it stays there, and ovf is set, until the vector ends.
- Products are zero-extended from 16 bits to ACC_W bits. A product of 0 still counts as a beat.
- A beat presented while in HOLD is not accepted. The upstream stage must hold it.
- out_count is never 0 in a delivered result. The range is 1..LEN.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0. Internally acc = 0, cnt = 0, ovf = 0, state = ACC.
- Latency: out_valid rises in the cycle after the terminating beat is accepted.
- Throughput:
  - One beat per cycle within a vector.
  - A one-cycle bubble minimum between vectors: HOLD with out_ready = 1 lasts exactly 1 cycle.
- in_ready is a function of state only. It never depends on in_valid, which avoids a combinational loop with the upstream stage.
- If out_ready is already 1 when HOLD is entered, the result transfers in that first HOLD cycle.
- A reset asserted mid-vector or during HOLD discards the partial sum and any pending result. On the following cycle all outputs are at their reset values.
- in_last on the LEN-th beat is redundant. The vector terminates once, with no extra or empty result.
- Inputs seen while rst = 1 are ignored.

## Structure
- Shared package hslp_acc_pkg holds:
  - the state enum (ACC, HOLD),
  - PROD_W = 16,
  - the default ACC_W and LEN constants.
- One sub-module: hslp_sat_add. It is a combinational ACC_W saturating adder with inputs a[ACC_W] and b[16], and outputs sum[ACC_W] and sat.
- The top level holds the FSM, the counter and the result registers.

## Test plan
- Reset, then 4 beats of prod = 100, 200, 300, 400 with in_last on the 4th and out_ready = 1:
  - out_sum = 1000, out_count = 4, out_ovf = 0,
  - out_valid goes high 1 cycle after the 4th beat,
  - in_ready goes low for 1 cycle.
- LEN = 16, 16 beats of prod = 65535, in_last never asserted: out_sum = 1048560, out_count = 16, the vector auto-terminates, out_ovf = 0.
- ACC_W = 17, 3 beats of 65535: out_sum = 131071, out_ovf = 1. The next vector, a single beat of 5 with in_last, gives out_sum = 5, out_ovf = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after a result and keep in_valid = 1:
  - out_sum stays stable and in_ready stays 0 throughout,
  - no beat is lost or double-counted once out_ready rises.
- Assert rst mid-vector after 2 beats: the next cycle shows all outputs at reset values, and a fresh 1-beat vector of 7 yields out_sum = 7, out_count = 1.
- Random valid gaps over 1000 vectors against a reference model: every out_sum and out_count matches, and the result count equals the number of terminations.

Source files
------------

// File: rtl/hslp_acc_pkg.sv
// Shared definitions for the approximate-product dot accumulator.
package hslp_acc_pkg;

    // Accumulate beats, or hold a finished result until the consumer takes it.
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width of one approximate product coming out of the 8x8 multiplier.
    localparam int PROD_W    = 16;

    // Default accumulator/result width and maximum vector length.
    localparam int ACC_W_DEF = 24;
    localparam int LEN_DEF   = 16;

endpackage

// File: rtl/hslp_sat_add.sv
// Combinational saturating adder: ACC_W-bit running sum plus a 16-bit product.
// The add is done one bit wider so the carry out flags a clip to all-ones.
module hslp_sat_add
    import hslp_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide_s;

    // Widened add, then clip to the largest representable value on carry out.
    always_comb begin
        wide_s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        sat    = wide_s[ACC_W];
        if (wide_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/hslp_dot_acc.sv
// Streaming saturating dot-product accumulator. Sums up to LEN approximate
// products per vector and presents the result on a valid/ready port.
// in_ready is a registered copy of (state == ACC), so it never depends on
// in_valid and cannot close a combinational loop with the upstream stage.
module hslp_dot_acc
    import hslp_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_e             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;

    logic               accept_s;
    logic               term_s;
    logic [ACC_W-1:0]   sum_s;
    logic               sat_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    hslp_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_r),
        .b   (prod),
        .sum (sum_s),
        .sat (sat_s)
    );

    assign accept_s  = in_valid && in_ready;
    assign cnt_inc_s = cnt_r + CNT_W'(1);
    // A vector ends on an explicit last beat or when the LEN-th beat arrives;
    // both together still end it only once.
    assign term_s    = in_last || (cnt_inc_s == CNT_W'(LEN));

    // FSM, running accumulator/counter and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ACC;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= {ACC_W{1'b0}};
            out_count <= {CNT_W{1'b0}};
            out_ovf   <= 1'b0;
        end else begin
            case (state_r)
                ACC: begin
                    if (accept_s) begin
                        if (term_s) begin
                            out_sum   <= sum_s;
                            out_count <= cnt_inc_s;
                            out_ovf   <= ovf_r | sat_s;
                            acc_r     <= {ACC_W{1'b0}};
                            cnt_r     <= {CNT_W{1'b0}};
                            ovf_r     <= 1'b0;
                            state_r   <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc_r <= sum_s;
                            cnt_r <= cnt_inc_s;
                            ovf_r <= ovf_r | sat_s;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r   <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ACC;
                    acc_r     <= {ACC_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                    ovf_r     <= 1'b0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hslp_dot_acc.sv
// Scoreboard bench for hslp_dot_acc: a 24-bit/LEN 16 instance for the main
// behaviour and a 17-bit instance for saturation.
module tb_hslp_dot_acc;

    localparam int W0 = 24;
    localparam int L0 = 16;
    localparam int C0 = $clog2(L0 + 1);
    localparam int W1 = 17;
    localparam int L1 = 16;
    localparam int C1 = $clog2(L1 + 1);

    typedef struct {
        longint sum;
        longint count;
        longint ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    exp_t ex;

    logic          clk;
    logic          rst;

    logic          v0, r0, l0, ov0, or0, of0;
    logic [15:0]   p0;
    logic [W0-1:0] os0;
    logic [C0-1:0] oc0;

    logic          v1, r1, l1, ov1, or1, of1;
    logic [15:0]   p1;
    logic [W1-1:0] os1;
    logic [C1-1:0] oc1;

    int checks = 0;
    int fails  = 0;
    int results0 = 0;
    int terms0   = 0;
    int results1 = 0;
    int terms1   = 0;
    int ready_mode = 1;

    hslp_dot_acc #(.ACC_W(W0), .LEN(L0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .prod(p0),
        .in_last(l0), .out_valid(ov0), .out_ready(or0), .out_sum(os0),
        .out_count(oc0), .out_ovf(of0)
    );

    hslp_dot_acc #(.ACC_W(W1), .LEN(L1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .prod(p1),
        .in_last(l1), .out_valid(ov1), .out_ready(or1), .out_sum(os1),
        .out_count(oc1), .out_ovf(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push0(input longint s, input longint c, input longint o);
        ex.sum = s; ex.count = c; ex.ovf = o;
        q0.push_back(ex);
        terms0++;
    endtask

    task automatic push1(input longint s, input longint c, input longint o);
        ex.sum = s; ex.count = c; ex.ovf = o;
        q1.push_back(ex);
        terms1++;
    endtask

    // Present one beat on dut0 (called at a negedge); returns at the negedge after acceptance.
    task automatic send0(input logic [15:0] p, input logic last);
        int n;
        n = 0;
        v0 = 1'b1; p0 = p; l0 = last;
        while (!r0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!r0) begin
            checks++; fails++;
            $display("FAIL send0_timeout: in_ready stayed %0d, required 1", r0);
        end
        @(negedge clk);
        v0 = 1'b0; l0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] p, input logic last);
        int n;
        n = 0;
        v1 = 1'b1; p1 = p; l1 = last;
        while (!r1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!r1) begin
            checks++; fails++;
            $display("FAIL send1_timeout: in_ready stayed %0d, required 1", r1);
        end
        @(negedge clk);
        v1 = 1'b0; l1 = 1'b0;
    endtask

    // Downstream ready for dut0, changed just after each rising edge.
    initial begin
        or0 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       or0 = 1'b0;
                1:       or0 = 1'b1;
                default: or0 = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor dut0: every completed transfer is popped and compared.
    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            if (q0.size() == 0) begin
                checks++; fails++;
                $display("FAIL mon0_unexpected: got sum %0d count %0d, required no result", os0, oc0);
            end else begin
                e0 = q0.pop_front();
                chk("mon0_sum", longint'(os0), e0.sum);
                chk("mon0_count", longint'(oc0), e0.count);
                chk("mon0_ovf", longint'(of0), e0.ovf);
            end
            results0++;
        end
    end

    // Monitor dut1.
    always @(negedge clk) begin
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) begin
                checks++; fails++;
                $display("FAIL mon1_unexpected: got sum %0d count %0d, required no result", os1, oc1);
            end else begin
                e1 = q1.pop_front();
                chk("mon1_sum", longint'(os1), e1.sum);
                chk("mon1_count", longint'(oc1), e1.count);
                chk("mon1_ovf", longint'(of1), e1.ovf);
            end
            results1++;
        end
    end

    initial begin
        longint acc;
        longint ovf;
        longint maxv;
        int     len;
        int     n;
        logic [15:0] pr;
        logic        lst;

        maxv = (longint'(1) << W0) - 1;
        rst = 1'b1;
        v0 = 1'b0; p0 = 16'd0; l0 = 1'b0;
        v1 = 1'b0; p1 = 16'd0; l1 = 1'b0;
        or1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(r0), 1);
        chk("rst_out_valid", longint'(ov0), 0);
        chk("rst_out_sum", longint'(os0), 0);
        chk("rst_out_count", longint'(oc0), 0);
        chk("rst_out_ovf", longint'(of0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic vector 100+200+300+400, then latency and one-cycle bubble.
        push0(1000, 4, 0);
        send0(16'd100, 1'b0);
        send0(16'd200, 1'b0);
        send0(16'd300, 1'b0);
        send0(16'd400, 1'b1);
        chk("lat_out_valid", longint'(ov0), 1);
        chk("lat_in_ready_low", longint'(r0), 0);
        @(negedge clk);
        chk("bubble_in_ready_back", longint'(r0), 1);
        chk("bubble_out_valid_low", longint'(ov0), 0);

        // Auto-termination at LEN with full-scale products.
        push0(1048560, 16, 0);
        for (int i = 0; i < 16; i++) send0(16'hFFFF, 1'b0);

        // in_last on the LEN-th beat must not create an extra result.
        push0(16, 16, 0);
        for (int i = 0; i < 16; i++) send0(16'd1, (i == 15));

        // Backpressure: result held for 10 cycles while a beat waits upstream.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        push0(30, 2, 0);
        send0(16'd10, 1'b0);
        send0(16'd20, 1'b1);
        v0 = 1'b1; p0 = 16'd30; l0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", longint'(ov0), 1);
            chk("bp_in_ready", longint'(r0), 0);
            chk("bp_out_sum", longint'(os0), 30);
            @(negedge clk);
        end
        ready_mode = 1;
        push0(30, 1, 0);
        send0(16'd30, 1'b1);

        // Reset mid-vector discards the partial sum.
        send0(16'd1, 1'b0);
        send0(16'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", longint'(r0), 1);
        chk("midrst_out_valid", longint'(ov0), 0);
        chk("midrst_out_sum", longint'(os0), 0);
        chk("midrst_out_count", longint'(oc0), 0);
        chk("midrst_out_ovf", longint'(of0), 0);
        rst = 1'b0;
        @(negedge clk);
        push0(7, 1, 0);
        send0(16'd7, 1'b1);

        // Saturation on the 17-bit instance, then a clean vector afterwards.
        push1(131071, 3, 1);
        send1(16'hFFFF, 1'b0);
        send1(16'hFFFF, 1'b0);
        send1(16'hFFFF, 1'b1);
        push1(5, 1, 0);
        send1(16'd5, 1'b1);

        // Random lengths, gaps and downstream stalls against a reference model.
        ready_mode = 2;
        for (int v = 0; v < 1000; v++) begin
            len = $urandom_range(1, 16);
            acc = 0;
            ovf = 0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                pr  = 16'($urandom_range(0, 65535));
                lst = (i == len - 1) ? ((len == 16) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                acc = acc + longint'(pr);
                if (acc > maxv) begin
                    acc = maxv;
                    ovf = 1;
                end
                if (i == len - 1) push0(acc, len, ovf);
                send0(pr, lst);
            end
        end

        // Drain outstanding results.
        ready_mode = 1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("results0_vs_terms", results0, terms0);
        chk("results1_vs_terms", results1, terms1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
